// File: rtl/aes128_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes128_round_ctrl_if
// Description : Block-input / ciphertext-output bundle for aes128_round_ctrl.
//               128-bit blocks carry byte 0 in bits [127:120] and byte 15 in
//               bits [7:0]. The bytes are column-major: byte 4c+r is state
//               column c, row r.
//               master : source of plaintext/key, consumer of ciphertext
//               slave  : the round controller
//               The abort signal is present only when AES_ABORT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface aes128_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;
`ifdef AES_ABORT_EN
    logic         abort;

    modport master (
        output in_valid, plaintext, key, out_ready, abort,
        input  in_ready, out_valid, ciphertext, busy, round
    );
    modport slave (
        input  in_valid, plaintext, key, out_ready, abort,
        output in_ready, out_valid, ciphertext, busy, round
    );
`else
    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round
    );
    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round
    );
`endif
endinterface
`default_nettype wire

// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes128_round_ctrl
// Description : Iterative AES-128 encryption controller. One cipher round is
//               computed per clock: SubBytes, ShiftRows, MixColumns (skipped
//               in the last round) and AddRoundKey. The round key is expanded
//               on the fly from the previous round key. The module accepts a
//               block in IDLE, runs for NR rounds in RUN, then holds the
//               ciphertext in DONE until the consumer takes it.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - aes128_round_ctrl_if.slave. Carries in_valid,
//                        in_ready, plaintext and key (block input), then
//                        out_valid, out_ready and ciphertext (output), then
//                        the busy and round status, and abort if enabled.
// Parameters  : NR          - number of cipher rounds; must be 10
//               HOLD_OUTPUT - 1: ciphertext is held after the output
//                             handshake; 0: ciphertext is cleared to 0
// Macros      : AES_ABORT_EN - adds the abort input. When abort is high in
//               RUN or DONE, the block is dropped and the FSM returns to IDLE.
// Revision    : 1.0  initial release
// ============================================================================
module aes128_round_ctrl #(
    parameter int NR          = 10,
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    aes128_round_ctrl_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_round_ctrl: NR must be 10 for AES-128");
    end

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;
    localparam logic [7:0] c_rcon_init  = 8'h01;
    localparam logic [3:0] c_last_round = 4'(NR);

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // The S-box is computed instead of stored as a table. The inverse is
    // x^254, built from the squares x^2, x^4, ... x^128. An input of 0
    // gives an inverse of 0, as the S-box requires. The affine transform
    // is applied to the result.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes and ShiftRows combined. Output (col c, row r) is taken from
    // input column (c + r) mod 4, same row.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        // SubWord(RotWord(w3)) with Rcon folded into the leading byte
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_ct;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;

    logic         w_abort;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic         w_accept;
    logic         w_last;
    logic [127:0] w_nk;
    logic [127:0] w_sr;
    logic [127:0] w_round_out;

`ifdef AES_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last      = (r_round == c_last_round);
    assign w_nk        = key_exp(r_key, r_rcon);
    assign w_sr        = sub_shift(r_state);
    assign w_round_out = (w_last ? w_sr : mix_columns(w_sr)) ^ w_nk;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= c_st_idle;
        else        r_fsm <= w_fsm_next;
    end

    // FSM next-state logic. Abort takes priority over a same-cycle output
    // handshake.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_st_idle: if (w_accept) w_fsm_next = c_st_run;
            c_st_run: begin
                if (w_abort)     w_fsm_next = c_st_idle;
                else if (w_last) w_fsm_next = c_st_done;
            end
            c_st_done: begin
                if (w_abort || bus.out_ready) w_fsm_next = c_st_idle;
            end
            default:   w_fsm_next = c_st_idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_fsm)
            c_st_idle: w_in_ready  = !w_abort;
            c_st_run:  w_busy      = 1'b1;
            c_st_done: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_ct    <= '0;
            r_rcon  <= c_rcon_init;
            r_round <= 4'd0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= bus.plaintext ^ bus.key;
                        r_key   <= bus.key;
                        r_rcon  <= c_rcon_init;
                        r_round <= 4'd1;
                    end
                end
                c_st_run: begin
                    if (w_abort) begin
                        r_state <= '0;
                        r_key   <= '0;
                        r_round <= 4'd0;
                    end else begin
                        r_state <= w_round_out;
                        r_key   <= w_nk;
                        r_rcon  <= xtime(r_rcon);
                        // In DONE, round keeps showing the final round index.
                        if (w_last) r_ct    <= w_round_out;
                        else        r_round <= r_round + 4'd1;
                    end
                end
                c_st_done: begin
                    if (w_abort) begin
                        r_state <= '0;
                        r_key   <= '0;
                        r_round <= 4'd0;
                    end else if (bus.out_ready) begin
                        r_round <= 4'd0;
                        if (!HOLD_OUTPUT) r_ct <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.busy       = w_busy;
    assign bus.ciphertext = r_ct;
    assign bus.round      = r_round;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_round_ctrl
// Description : Self-checking bench for aes128_round_ctrl. It uses the
//               FIPS-197 known-answer vectors. Expected ciphertexts are
//               pushed to a queue when a block is accepted and popped on
//               each output handshake. Define AES_ABORT_EN to also run
//               the abort scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_round_ctrl;

    localparam logic [127:0] c_key_b   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_pt_b    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct_b    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_key_c   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt_c    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct_c    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_r1_st_c = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] c_r1_k_c  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aes128_round_ctrl_if bus();

    aes128_round_ctrl #(
        .NR          (10),
        .HOLD_OUTPUT (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block and returns once it has been accepted or the budget runs out.
    task automatic offer(input logic [127:0] pt, input logic [127:0] k, output bit ok);
        ok = 1'b0;
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Counts clock edges until out_valid is seen.
    task automatic wait_out(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.plaintext = '0;  bus.key = '0;
`ifdef AES_ABORT_EN
        bus.abort = 1'b0;
`endif
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.round !== 4'd0) $display("FAIL reset_round: got %0d want 0", bus.round); else n_pass++;
        n_checks++; if (bus.ciphertext !== 128'h0) $display("FAIL reset_ct: got %h want 0", bus.ciphertext); else n_pass++;
        n_checks++; if (dut.r_rcon !== 8'h01) $display("FAIL reset_rcon: got %h want 01", dut.r_rcon); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_fips_b();
        bit ok;
        int lat;
        logic [127:0] exp;
        offer(c_pt_b, c_key_b, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL b_accept: got %b want 1", ok); else n_pass++;
        sb.push_back(c_ct_b);
        wait_out(lat, ok);
        n_checks++; if (!ok || lat !== 10) $display("FAIL b_latency: got %0d edges want 10", lat); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) $display("FAIL b_done_flags: got in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy); else n_pass++;
        exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.ciphertext !== exp) $display("FAIL b_ct: got %h want %h", bus.ciphertext, exp); else n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.round !== 4'd0) $display("FAIL b_after_hs: got out_valid=%b in_ready=%b round=%0d want 0/1/0", bus.out_valid, bus.in_ready, bus.round); else n_pass++;
        n_checks++; if (bus.ciphertext !== c_ct_b) $display("FAIL b_ct_hold: got %h want %h", bus.ciphertext, c_ct_b); else n_pass++;
    endtask

    task automatic test_fips_c_rounds();
        bit ok;
        logic [127:0] exp;
        offer(c_pt_c, c_key_c, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL c_accept: got %b want 1", ok); else n_pass++;
        sb.push_back(c_ct_c);
        n_checks++; if (bus.round !== 4'd1 || dut.r_state !== (c_pt_c ^ c_key_c)) $display("FAIL c_round0: got round=%0d state=%h want 1/%h", bus.round, dut.r_state, c_pt_c ^ c_key_c); else n_pass++;
        tick();
        n_checks++; if (dut.r_state !== c_r1_st_c) $display("FAIL c_r1_state: got %h want %h", dut.r_state, c_r1_st_c); else n_pass++;
        n_checks++; if (dut.r_key !== c_r1_k_c) $display("FAIL c_r1_key: got %h want %h", dut.r_key, c_r1_k_c); else n_pass++;
        n_checks++; if (bus.round !== 4'd2) $display("FAIL c_round_2: got %0d want 2", bus.round); else n_pass++;
        for (int k = 3; k <= 10; k++) begin
            tick();
            n_checks++; if (bus.round !== 4'(k) || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL c_round_%0d: got round=%0d out_valid=%b busy=%b", k, bus.round, bus.out_valid, bus.busy); else n_pass++;
        end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL c_out_valid: got %b want 1", bus.out_valid); else n_pass++;
        exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.ciphertext !== exp) $display("FAIL c_ct: got %h want %h", bus.ciphertext, exp); else n_pass++;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        bit stable;
        logic [127:0] ct0;
        logic [127:0] exp;
        offer(c_pt_b, c_key_b, ok);
        sb.push_back(c_ct_b);
        wait_out(lat, ok);
        n_checks++; if (!ok) $display("FAIL bp_out_valid: got timeout want out_valid"); else n_pass++;
        ct0 = bus.ciphertext;
        stable = 1'b1;
        bus.plaintext = c_pt_c; bus.key = c_key_c; bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ciphertext !== ct0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_hold: got ct=%h in_ready=%b out_valid=%b want stable", bus.ciphertext, bus.in_ready, bus.out_valid); else n_pass++;
        exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.ciphertext !== exp) $display("FAIL bp_ct1: got %h want %h", bus.ciphertext, exp); else n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); else n_pass++;
        offer(c_pt_c, c_key_c, ok);
        sb.push_back(c_ct_c);
        wait_out(lat, ok);
        n_checks++; if (!ok || lat !== 10) $display("FAIL bp_latency2: got %0d want 10", lat); else n_pass++;
        exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.ciphertext !== exp) $display("FAIL bp_ct2: got %h want %h", bus.ciphertext, exp); else n_pass++;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int lat;
        logic [127:0] exp;
        offer(c_pt_c, c_key_c, ok);
        sb.push_back(c_ct_c);
        for (int i = 0; i < 20 && bus.round !== 4'd5; i++) tick();
        n_checks++; if (bus.round !== 4'd5) $display("FAIL rst_reach_r5: got %0d want 5", bus.round); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.in_ready !== 1'b1) $display("FAIL rst_async: got out_valid=%b busy=%b round=%0d in_ready=%b want 0/0/0/1", bus.out_valid, bus.busy, bus.round, bus.in_ready); else n_pass++;
        n_checks++; if (bus.ciphertext !== 128'h0) $display("FAIL rst_ct: got %h want 0", bus.ciphertext); else n_pass++;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        offer(c_pt_b, c_key_b, ok);
        sb.push_back(c_ct_b);
        wait_out(lat, ok);
        n_checks++; if (!ok || lat !== 10) $display("FAIL rst_latency: got %0d want 10", lat); else n_pass++;
        exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.ciphertext !== exp) $display("FAIL rst_ct_after: got %h want %h", bus.ciphertext, exp); else n_pass++;
        tick();
        bus.out_ready = 1'b0;
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        bit ok;
        int lat;
        bit never;
        bus.abort = 1'b1;
        bus.plaintext = c_pt_b; bus.key = c_key_b; bus.in_valid = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL ab_idle_ready: got %b want 0", bus.in_ready); else n_pass++;
        tick();
        bus.in_valid = 1'b0; bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL ab_idle_accept: got busy=%b want 0", bus.busy); else n_pass++;
        offer(c_pt_b, c_key_b, ok);
        sb.push_back(c_ct_b);
        for (int i = 0; i < 20 && bus.round !== 4'd3; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.round !== 4'd0 || dut.r_state !== 128'h0 || dut.r_key !== 128'h0) $display("FAIL ab_run: got busy=%b round=%0d state=%h want 0/0/0", bus.busy, bus.round, dut.r_state); else n_pass++;
        sb.delete();
        never = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.out_valid !== 1'b0) never = 1'b0;
            tick();
        end
        n_checks++; if (never !== 1'b1) $display("FAIL ab_no_output: got out_valid=1 want 0"); else n_pass++;
        offer(c_pt_b, c_key_b, ok);
        sb.push_back(c_ct_b);
        wait_out(lat, ok);
        bus.abort = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round !== 4'd0) $display("FAIL ab_done: got out_valid=%b busy=%b round=%0d want 0/0/0", bus.out_valid, bus.busy, bus.round); else n_pass++;
        n_checks++; if (bus.ciphertext !== c_ct_b) $display("FAIL ab_ct_kept: got %h want %h", bus.ciphertext, c_ct_b); else n_pass++;
        sb.delete();
    endtask
`endif

    task automatic test_back_to_back();
        logic [127:0] vec_pt[3];
        logic [127:0] vec_k[3];
        logic [127:0] vec_ct[3];
        logic [127:0] exp;
        int  idx;
        int  outs;
        int  cyc;
        int  acc_cyc[3];
        bit  accept;
        vec_pt = '{c_pt_b, c_pt_c, c_pt_b};
        vec_k  = '{c_key_b, c_key_c, c_key_b};
        vec_ct = '{c_ct_b, c_ct_c, c_ct_b};
        idx = 0; outs = 0; cyc = 0;
        bus.out_ready = 1'b1;
        while (outs < 3 && cyc < 100) begin
            if (idx < 3) begin
                bus.in_valid  = 1'b1;
                bus.plaintext = vec_pt[idx];
                bus.key       = vec_k[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            accept = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 128'hx;
                n_checks++; if (bus.ciphertext !== exp) $display("FAIL b2b_ct_%0d: got %h want %h", outs, bus.ciphertext, exp); else n_pass++;
                outs++;
            end
            tick();
            cyc++;
            if (accept) begin
                sb.push_back(vec_ct[idx]);
                acc_cyc[idx] = cyc;
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (outs !== 3) $display("FAIL b2b_count: got %0d outputs want 3", outs); else n_pass++;
        n_checks++; if (idx !== 3 || acc_cyc[1] - acc_cyc[0] !== 12 || acc_cyc[2] - acc_cyc[1] !== 12) $display("FAIL b2b_period: got %0d,%0d want 12,12", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c_rounds();
        test_backpressure();
        test_reset_midrun();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
